// File: rtl/usb_rx_nrzi_decoder.sv
// USB receive line decoder: NRZI decode, SYNC hunt, bit unstuffing, EOP and line-error detection.
// Every decision is taken on a bit_valid cycle and shows up on registered outputs one clock later.
module usb_rx_nrzi_decoder #(
  parameter int SYNC_MIN_ZEROS = 5
) (
  input  logic clk,
  input  logic nRST,
  input  logic bit_valid,
  input  logic dp,
  input  logic dm,
  output logic serial_out,
  output logic shift_enable,
  output logic rx_active,
  output logic sync_det,
  output logic eop,
  output logic rx_error
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ACTIVE,
    ST_EOP,
    ST_ABORT
  } state_t;

  localparam logic [2:0] SYNC_THR = 3'(SYNC_MIN_ZEROS);

  state_t     state_q, state_d;
  logic       prev_line_q, prev_line_d;   // 1 = J, 0 = K
  logic [2:0] zero_cnt_q, zero_cnt_d;
  logic [2:0] ones_run_q, ones_run_d;
  logic [2:0] bit_cnt_q, bit_cnt_d;
  logic [1:0] se0_cnt_q, se0_cnt_d;
  logic       serial_out_q, serial_out_d;
  logic       shift_enable_q, shift_enable_d;
  logic       rx_active_q, rx_active_d;
  logic       sync_det_q, sync_det_d;
  logic       eop_q, eop_d;
  logic       rx_error_q, rx_error_d;

  logic line_j, line_jk, line_se0, nrzi_bit;

  assign line_j   = dp & ~dm;
  assign line_jk  = dp ^ dm;
  assign line_se0 = ~dp & ~dm;
  // J/K matching the previous J/K decodes as 1; dp alone identifies J vs K
  assign nrzi_bit = (dp == prev_line_q);

  always_comb begin
    state_d        = state_q;
    prev_line_d    = prev_line_q;
    zero_cnt_d     = zero_cnt_q;
    ones_run_d     = ones_run_q;
    bit_cnt_d      = bit_cnt_q;
    se0_cnt_d      = se0_cnt_q;
    rx_active_d    = rx_active_q;
    serial_out_d   = 1'b0;
    shift_enable_d = 1'b0;
    sync_det_d     = 1'b0;
    eop_d          = 1'b0;
    rx_error_d     = 1'b0;

    if (bit_valid) begin
      if (line_jk) begin
        prev_line_d = dp;
      end

      unique case (state_q)
        ST_IDLE: begin
          if (line_jk) begin
            if (!nrzi_bit) begin
              zero_cnt_d = (zero_cnt_q == 3'd7) ? 3'd7 : zero_cnt_q + 3'd1;
            end else if (zero_cnt_q >= SYNC_THR) begin
              sync_det_d  = 1'b1;
              rx_active_d = 1'b1;
              ones_run_d  = 3'd1;
              bit_cnt_d   = 3'd0;
              zero_cnt_d  = 3'd0;
              state_d     = ST_ACTIVE;
            end else begin
              zero_cnt_d = 3'd0;
            end
          end else begin
            zero_cnt_d  = 3'd0;
            prev_line_d = 1'b1;
          end
        end

        ST_ACTIVE: begin
          if (line_jk) begin
            if (ones_run_q == 3'd6) begin
              // after six ones the next bit must be a stuffed zero, which is discarded
              if (!nrzi_bit) begin
                ones_run_d = 3'd0;
              end else begin
                rx_error_d  = 1'b1;
                rx_active_d = 1'b0;
                state_d     = ST_ABORT;
              end
            end else begin
              shift_enable_d = 1'b1;
              serial_out_d   = nrzi_bit;
              bit_cnt_d      = bit_cnt_q + 3'd1;
              ones_run_d     = nrzi_bit ? ones_run_q + 3'd1 : 3'd0;
            end
          end else if (line_se0) begin
            se0_cnt_d = 2'd1;
            state_d   = ST_EOP;
          end else begin
            rx_error_d  = 1'b1;
            rx_active_d = 1'b0;
            state_d     = ST_ABORT;
          end
        end

        ST_EOP: begin
          if (line_se0) begin
            se0_cnt_d = (se0_cnt_q == 2'd3) ? 2'd3 : se0_cnt_q + 2'd1;
          end else if (line_j && (se0_cnt_q >= 2'd2)) begin
            eop_d       = 1'b1;
            rx_error_d  = (bit_cnt_q != 3'd0);
            rx_active_d = 1'b0;
            prev_line_d = 1'b1;
            zero_cnt_d  = 3'd0;
            state_d     = ST_IDLE;
          end else begin
            rx_error_d  = 1'b1;
            rx_active_d = 1'b0;
            if (line_j) begin
              prev_line_d = 1'b1;
              zero_cnt_d  = 3'd0;
              state_d     = ST_IDLE;
            end else begin
              state_d = ST_ABORT;
            end
          end
        end

        ST_ABORT: begin
          if (line_j) begin
            prev_line_d = 1'b1;
            zero_cnt_d  = 3'd0;
            state_d     = ST_IDLE;
          end
        end

        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST) begin
      state_q        <= ST_IDLE;
      prev_line_q    <= 1'b1;
      zero_cnt_q     <= 3'd0;
      ones_run_q     <= 3'd0;
      bit_cnt_q      <= 3'd0;
      se0_cnt_q      <= 2'd0;
      serial_out_q   <= 1'b0;
      shift_enable_q <= 1'b0;
      rx_active_q    <= 1'b0;
      sync_det_q     <= 1'b0;
      eop_q          <= 1'b0;
      rx_error_q     <= 1'b0;
    end else begin
      state_q        <= state_d;
      prev_line_q    <= prev_line_d;
      zero_cnt_q     <= zero_cnt_d;
      ones_run_q     <= ones_run_d;
      bit_cnt_q      <= bit_cnt_d;
      se0_cnt_q      <= se0_cnt_d;
      serial_out_q   <= serial_out_d;
      shift_enable_q <= shift_enable_d;
      rx_active_q    <= rx_active_d;
      sync_det_q     <= sync_det_d;
      eop_q          <= eop_d;
      rx_error_q     <= rx_error_d;
    end
  end

  assign serial_out   = serial_out_q;
  assign shift_enable = shift_enable_q;
  assign rx_active    = rx_active_q;
  assign sync_det     = sync_det_q;
  assign eop          = eop_q;
  assign rx_error     = rx_error_q;

endmodule

// File: tb/tb_usb_rx_nrzi_decoder.sv
// Bench for usb_rx_nrzi_decoder: directed packets plus random traffic, checked every cycle
// against a queue-based model of the line protocol, with literal per-packet expectations.
module tb_usb_rx_nrzi_decoder;

  localparam int N = 5;

  logic clk = 1'b0;
  logic nRST = 1'b1;
  logic bit_valid = 1'b0;
  logic dp = 1'b1;
  logic dm = 1'b0;
  logic serial_out, shift_enable, rx_active, sync_det, eop, rx_error;

  usb_rx_nrzi_decoder #(.SYNC_MIN_ZEROS(N)) dut (
    .clk(clk), .nRST(nRST), .bit_valid(bit_valid), .dp(dp), .dm(dm),
    .serial_out(serial_out), .shift_enable(shift_enable), .rx_active(rx_active),
    .sync_det(sync_det), .eop(eop), .rx_error(rx_error)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  bit chk_en = 1'b0;

  // ---------------- reference model ----------------
  int   ph;          // 0 hunting, 1 in packet, 2 in EOP, 3 aborted
  logic m_last;      // dp of the last J/K seen
  bit   hunt_q[$];   // decoded bits since the hunt (re)started
  bit   raw_q[$];    // decoded packet bits incl. SYNC's final 1 and stuff zeros
  int   fwd;         // data bits forwarded in this packet
  int   se0n;
  logic exp_so = 1'b0, exp_se = 1'b0, exp_act = 1'b0;
  logic exp_sync = 1'b0, exp_eop = 1'b0, exp_err = 1'b0;

  function automatic int hunt_tail_zeros();
    int n = 0;
    for (int i = hunt_q.size() - 1; i >= 0; i--) begin
      if (hunt_q[i] != 1'b0) break;
      n++;
    end
    return n;
  endfunction

  function automatic int raw_tail_ones();
    int n = 0;
    for (int i = raw_q.size() - 1; i >= 0; i--) begin
      if (raw_q[i] != 1'b1) break;
      n++;
    end
    return n;
  endfunction

  task automatic model_reset();
    ph = 0; m_last = 1'b1; hunt_q.delete(); raw_q.delete(); fwd = 0; se0n = 0;
    exp_so = 0; exp_se = 0; exp_act = 0; exp_sync = 0; exp_eop = 0; exp_err = 0;
  endtask

  task automatic model_abort();
    exp_err = 1'b1; exp_act = 1'b0; ph = 3;
  endtask

  task automatic model_step(input logic v, input logic p, input logic m);
    logic jk, b, isj, isse0;
    exp_so = 0; exp_se = 0; exp_sync = 0; exp_eop = 0; exp_err = 0;
    if (!v) return;
    jk = p ^ m; b = (p == m_last); isj = p & ~m; isse0 = ~p & ~m;
    case (ph)
      0: begin
        if (jk) begin
          if (b && hunt_tail_zeros() >= N) begin
            exp_sync = 1'b1; exp_act = 1'b1; ph = 1;
            raw_q.delete(); raw_q.push_back(1'b1); fwd = 0; hunt_q.delete();
          end else begin
            hunt_q.push_back(b);
            if (hunt_q.size() > 16) void'(hunt_q.pop_front());
          end
        end else begin
          hunt_q.delete();
        end
      end
      1: begin
        if (jk) begin
          if (raw_tail_ones() == 6) begin
            if (!b) raw_q.push_back(1'b0);
            else model_abort();
          end else begin
            exp_se = 1'b1; exp_so = b; fwd++;
            raw_q.push_back(b);
          end
          if (raw_q.size() > 8) void'(raw_q.pop_front());
        end else if (isse0) begin
          se0n = 1; ph = 2;
        end else begin
          model_abort();
        end
      end
      2: begin
        if (isse0) se0n++;
        else if (isj) begin
          if (se0n >= 2) begin
            exp_eop = 1'b1; exp_err = (fwd % 8) != 0;
          end else begin
            exp_err = 1'b1;
          end
          exp_act = 1'b0; ph = 0; hunt_q.delete();
        end else begin
          model_abort();
        end
      end
      default: begin
        if (isj) begin ph = 0; hunt_q.delete(); end
      end
    endcase
    if (jk) m_last = p;
    else if (ph == 0) m_last = 1'b1;
  endtask

  // ---------------- per-cycle compare and statistics ----------------
  int n_se, n_sync, n_eop, n_err, n_both;
  bit cap_q[$];

  always @(negedge clk) begin
    if (chk_en) begin
      tests++;
      if (shift_enable !== exp_se || rx_active !== exp_act || sync_det !== exp_sync ||
          eop !== exp_eop || rx_error !== exp_err || (exp_se && serial_out !== exp_so)) begin
        fails++;
        $display("FAIL cycle_cmp t=%0t got se=%b so=%b act=%b sync=%b eop=%b err=%b want se=%b so=%b act=%b sync=%b eop=%b err=%b",
                 $time, shift_enable, serial_out, rx_active, sync_det, eop, rx_error,
                 exp_se, exp_so, exp_act, exp_sync, exp_eop, exp_err);
      end
      if (shift_enable) begin n_se++; cap_q.push_back(serial_out); end
      if (sync_det) n_sync++;
      if (eop) n_eop++;
      if (rx_error) n_err++;
      if (eop && rx_error) n_both++;
    end
  end

  task automatic clear_stats();
    n_se = 0; n_sync = 0; n_eop = 0; n_err = 0; n_both = 0; cap_q.delete();
  endtask

  function automatic int cap_byte(input int start);
    logic [7:0] v = 8'h00;
    for (int i = 0; i < 8; i++) if (start + i < cap_q.size()) v[i] = cap_q[start + i];
    return int'(v);
  endfunction

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s got %0d want %0d", name, act, exp);
    end
  endtask

  // ---------------- stimulus ----------------
  bit gap_en = 1'b0;
  logic tx_dp = 1'b1;
  int tx_ones = 0;

  task automatic step(input logic v, input logic p, input logic m);
    bit_valid = v; dp = p; dm = m;
    @(posedge clk);
    if (nRST) model_step(v, p, m);
    else model_reset();
    @(negedge clk);
  endtask

  // kind: 0 J, 1 K, 2 SE0, 3 SE1
  task automatic send_line(input int kind);
    if (gap_en) repeat ($urandom_range(0, 2)) step(1'b0, 1'($urandom), 1'($urandom));
    case (kind)
      0: begin tx_dp = 1'b1; step(1'b1, 1'b1, 1'b0); end
      1: begin tx_dp = 1'b0; step(1'b1, 1'b0, 1'b1); end
      2: step(1'b1, 1'b0, 1'b0);
      default: step(1'b1, 1'b1, 1'b1);
    endcase
  endtask

  task automatic send_bit(input bit b);
    if (!b) tx_dp = ~tx_dp;
    send_line(tx_dp ? 0 : 1);
  endtask

  task automatic send_sync();
    repeat (7) send_bit(1'b0);
    send_bit(1'b1);
    tx_ones = 1;
  endtask

  task automatic send_data_bit(input bit b);
    send_bit(b);
    tx_ones = b ? tx_ones + 1 : 0;
    if (tx_ones == 6) begin
      send_bit(1'b0);
      tx_ones = 0;
    end
  endtask

  task automatic send_byte(input logic [7:0] v);
    for (int i = 0; i < 8; i++) send_data_bit(v[i]);
  endtask

  task automatic send_eop(input int n_se0);
    repeat (n_se0) send_line(2);
    send_line(0);
  endtask

  task automatic idle(input int n);
    repeat (n) step(1'b0, 1'b1, 1'b0);
  endtask

  task automatic basic_packet();
    clear_stats();
    repeat (3) send_line(0);
    send_sync();
    send_byte(8'hA5);
    send_eop(2);
    idle(2);
    check("basic_sync", n_sync, 1);
    check("basic_shifts", n_se, 8);
    check("basic_byte", cap_byte(0), 'hA5);
    check("basic_eop", n_eop, 1);
    check("basic_err", n_err, 0);
  endtask

  initial begin
    model_reset();
    #1 nRST = 1'b0;
    repeat (2) @(negedge clk);
    chk_en = 1'b1;
    @(negedge clk);
    check("rst_serial_out", int'(serial_out), 0);
    check("rst_shift_enable", int'(shift_enable), 0);
    check("rst_rx_active", int'(rx_active), 0);
    check("rst_sync_det", int'(sync_det), 0);
    check("rst_eop", int'(eop), 0);
    check("rst_rx_error", int'(rx_error), 0);
    nRST = 1'b1;
    idle(2);

    basic_packet();
    gap_en = 1'b1;
    basic_packet();
    gap_en = 1'b0;

    // bit stuffing
    clear_stats();
    repeat (2) send_line(0);
    send_sync();
    send_byte(8'hFF);
    send_byte(8'hFF);
    send_eop(2);
    idle(2);
    check("stuff_shifts", n_se, 16);
    check("stuff_byte0", cap_byte(0), 'hFF);
    check("stuff_byte1", cap_byte(8), 'hFF);
    check("stuff_err", n_err, 0);
    check("stuff_eop", n_eop, 1);

    // stuff error, then recovery with a fresh packet
    clear_stats();
    repeat (2) send_line(0);
    send_sync();
    repeat (6) send_bit(1'b1);
    idle(2);
    check("stferr_shifts", n_se, 5);
    check("stferr_err", n_err, 1);
    check("stferr_active", int'(rx_active), 0);
    repeat (2) send_line(0);
    send_sync();
    send_byte(8'h3C);
    send_eop(2);
    idle(2);
    check("stferr_resync", n_sync, 2);
    check("stferr_byte", cap_byte(5), 'h3C);
    check("stferr_eop", n_eop, 1);

    // bad EOP: single SE0
    clear_stats();
    repeat (2) send_line(0);
    send_sync();
    send_byte(8'h96);
    send_eop(1);
    idle(2);
    check("badeop_err", n_err, 1);
    check("badeop_eop", n_eop, 0);
    check("badeop_active", int'(rx_active), 0);

    // non-byte-multiple packet
    clear_stats();
    repeat (2) send_line(0);
    send_sync();
    send_byte(8'h5A);
    send_data_bit(1'b1);
    send_data_bit(1'b0);
    send_eop(2);
    idle(2);
    check("nonbyte_shifts", n_se, 10);
    check("nonbyte_both", n_both, 1);

    // reset mid-payload
    clear_stats();
    repeat (2) send_line(0);
    send_sync();
    for (int i = 0; i < 4; i++) send_data_bit(1'(8'hA5 >> i));
    check("pre_rst_active", int'(rx_active), 1);
    #2 nRST = 1'b0;
    model_reset();
    #1;
    check("midrst_active", int'(rx_active), 0);
    check("midrst_shift", int'(shift_enable), 0);
    check("midrst_so", int'(serial_out), 0);
    repeat (3) step(1'b1, 1'b0, 1'b1);
    nRST = 1'b1;
    clear_stats();
    for (int i = 4; i < 8; i++) send_data_bit(1'(8'hA5 >> i));
    send_eop(2);
    idle(2);
    check("postrst_pulses", n_se + n_sync + n_eop + n_err, 0);

    // random traffic against the model
    for (int p = 0; p < 60; p++) begin
      gap_en = ($urandom % 3) == 0;
      repeat ($urandom_range(1, 3)) send_line(0);
      if ($urandom % 4 == 0) begin
        repeat ($urandom_range(1, 5)) send_line(int'($urandom % 4));
        repeat (2) send_line(0);
      end
      send_sync();
      repeat ($urandom_range(0, 20)) send_data_bit(($urandom % 4) != 0);
      if ($urandom % 8 == 0) repeat (7) send_bit(1'b1);
      case ($urandom % 5)
        0, 1: send_eop(2);
        2: send_eop(1);
        3: send_eop(3);
        default: begin
          send_line(2);
          send_line(($urandom % 2) ? 1 : 3);
          send_line(0);
        end
      endcase
      idle($urandom_range(0, 2));
    end
    idle(3);

    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
